// File: rtl/mem_read_unit.sv
// Read-side memory controller for the multicycle MIPS datapath: takes a load
// request, runs a req/ack handshake to word memory and returns the extended datum.
module mem_read_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_req,
  input  logic [WIDTH-1:0] rd_addr,
  input  logic [1:0]       rd_size,
  input  logic             rd_signed,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_done,
  output logic             rd_err,
  output logic             busy,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  size_t           lat_size;
  logic            lat_signed;
  logic [1:0]      lat_lane;
  logic            illegal;
  logic            accept;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [WIDTH-1:0] ext_data;

  assign accept = (state == S_IDLE) && rd_req;

  // Alignment and size legality of the incoming request.
  always_comb begin
    illegal = 1'b0;
    case (size_t'(rd_size))
      SZ_BYTE: illegal = 1'b0;
      SZ_HALF: illegal = rd_addr[0];
      SZ_WORD: illegal = (rd_addr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  // Lane select and extension of the returned word, driven by the latched request.
  always_comb begin
    lane_byte = mem_rdata[{lat_lane, 3'b000} +: 8];
    lane_half = lat_lane[1] ? mem_rdata[16 +: 16] : mem_rdata[0 +: 16];
    case (lat_size)
      SZ_BYTE: ext_data = {{(WIDTH-8){lat_signed & lane_byte[7]}}, lane_byte};
      SZ_HALF: ext_data = {{(WIDTH-16){lat_signed & lane_half[15]}}, lane_half};
      default: ext_data = mem_rdata;
    endcase
  end

  // NOTE: every signal is given a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (rd_req) begin
          if (illegal) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_REQ;
            cnt_nxt   = '0;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_nxt = S_DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request fields are captured once at accept and held for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr   <= '0;
      lat_size   <= SZ_BYTE;
      lat_signed <= 1'b0;
      lat_lane   <= 2'b00;
    end else if (accept) begin
      mem_addr   <= {rd_addr[WIDTH-1:2], 2'b00};
      lat_size   <= size_t'(rd_size);
      lat_signed <= rd_signed;
      lat_lane   <= rd_addr[1:0];
    end
  end

  // Outputs are registered; status pulses follow the state they report by one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      mem_req <= 1'b0;
      rd_done <= 1'b0;
      rd_err  <= 1'b0;
      rd_data <= '0;
    end else begin
      busy    <= (state_nxt != S_IDLE);
      mem_req <= (state_nxt == S_REQ);
      rd_done <= (state == S_DONE);
      rd_err  <= (state == S_ERR);
      if ((state == S_REQ) && mem_ack) begin
        rd_data <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_read_unit.sv
// Self-checking bench for mem_read_unit: a transaction-level model schedules the
// expected output of every cycle; one compare process checks the DUT each cycle.
module tb_mem_read_unit;

  localparam int NCYC = 16384;

  logic        clk;
  logic        reset;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic        rd_signed;
  logic [31:0] rd_data;
  logic        rd_done;
  logic        rd_err;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_read_unit #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_size   (rd_size),
    .rd_signed (rd_signed),
    .rd_data   (rd_data),
    .rd_done   (rd_done),
    .rd_err    (rd_err),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    bit          bsy;
    bit          done;
    bit          err;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [NCYC];
  int          cyc = 0;
  int          next_free = 0;
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;
  logic [31:0] model_last = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, expv);
    end
  endtask

  // Load result from the architectural rules: shift the word, mask, extend.
  function automatic logic [31:0] ext_model(input logic [31:0] a, input logic [1:0] sz,
                                             input bit sg, input logic [31:0] w);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (sg && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic bit is_illegal(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  task automatic clear_exp(input int from);
    for (int i = from; i < NCYC; i++) exp_q[i] = '{0, 0, 0, 0, 32'h0, 32'h0};
  endtask

  // Per-cycle comparison against the scheduled expectations.
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      check("mem_req", {31'h0, mem_req}, {31'h0, exp_q[cyc].req});
      check("busy",    {31'h0, busy},    {31'h0, exp_q[cyc].bsy});
      check("rd_done", {31'h0, rd_done}, {31'h0, exp_q[cyc].done});
      check("rd_err",  {31'h0, rd_err},  {31'h0, exp_q[cyc].err});
      if (exp_q[cyc].req) check("mem_addr", mem_addr, exp_q[cyc].addr);
      if (exp_q[cyc].done || exp_q[cyc].err) check("rd_data", rd_data, exp_q[cyc].data);
    end
  end

  // One load. Called at a negedge; returns at the negedge before the earliest
  // edge at which the next request can be accepted. d = ack delay in REQ cycles
  // (0 = ack in first REQ cycle); d > 15 means memory never answers.
  task automatic txn(input logic [31:0] a, input logic [1:0] sz, input bit sg,
                     input logic [31:0] w, input int d, input bit noise);
    int n;
    bit ill;
    bit respond;
    logic [31:0] v;
    while (cyc + 1 < next_free) @(negedge clk);
    rd_req = 1'b1; rd_addr = a; rd_size = sz; rd_signed = sg;
    n   = cyc + 1;
    ill = is_illegal(a, sz);
    respond = !ill && d >= 0 && d <= 15;
    if (ill) begin
      exp_q[n].bsy      = 1'b1;
      exp_q[n + 1].err  = 1'b1;
      exp_q[n + 1].data = model_last;
      next_free = n + 2;
    end else if (respond) begin
      v = ext_model(a, sz, sg, w);
      for (int i = 0; i <= d; i++) begin
        exp_q[n + i].req  = 1'b1;
        exp_q[n + i].addr = {a[31:2], 2'b00};
      end
      for (int i = 0; i <= d + 1; i++) exp_q[n + i].bsy = 1'b1;
      exp_q[n + d + 2].done = 1'b1;
      exp_q[n + d + 2].data = v;
      model_last = v;
      next_free  = n + d + 3;
    end else begin
      for (int i = 0; i < 16; i++) begin
        exp_q[n + i].req  = 1'b1;
        exp_q[n + i].addr = {a[31:2], 2'b00};
      end
      for (int i = 0; i <= 16; i++) exp_q[n + i].bsy = 1'b1;
      exp_q[n + 17].err  = 1'b1;
      exp_q[n + 17].data = model_last;
      next_free = n + 18;
    end
    @(negedge clk);
    while (cyc < next_free - 1) begin
      rd_req    = noise && (cyc == n);
      rd_addr   = $urandom;
      rd_size   = 2'($urandom_range(0, 3));
      rd_signed = 1'($urandom_range(0, 1));
      mem_ack   = (respond && cyc == n + d) || (ill && cyc == n) ||
                  (!ill && !respond && cyc == n + 16);
      mem_rdata = (respond && cyc == n + d) ? w : $urandom;
      @(negedge clk);
    end
    rd_req  = 1'b0;
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    int          d;
    clear_exp(0);
    reset = 1'b1; rd_req = 1'b0; rd_addr = 32'h0; rd_size = 2'd0; rd_signed = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #3;
    check("rst_rd_data",  rd_data, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_flags", {27'h0, rd_done, rd_err, busy, mem_req, 1'b0}, 32'h0);

    // Pin the model to hand-computed values.
    check("pin_lb_s",  ext_model(32'h103, 2'd0, 1'b1, 32'h80112233), 32'hFFFFFF80);
    check("pin_lbu",   ext_model(32'h103, 2'd0, 1'b0, 32'h80112233), 32'h00000080);
    check("pin_lh_s",  ext_model(32'h102, 2'd1, 1'b1, 32'h8001FFFF), 32'hFFFF8001);
    check("pin_lhu",   ext_model(32'h100, 2'd1, 1'b0, 32'h8001FFFF), 32'h0000FFFF);
    check("pin_lb_b1", ext_model(32'h101, 2'd0, 1'b1, 32'h0000_7F00), 32'h0000007F);

    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    next_free = cyc + 1;

    txn(32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 2, 1'b0);
    check("lw_data_lit", rd_data, 32'hDEADBEEF);
    check("lw_addr_lit", mem_addr, 32'h100);
    txn(32'h103, 2'd0, 1'b1, 32'h80112233, 1, 1'b1);
    check("lb_s_lit", rd_data, 32'hFFFFFF80);
    txn(32'h103, 2'd0, 1'b0, 32'h80112233, 0, 1'b0);
    check("lbu_lit", rd_data, 32'h00000080);
    txn(32'h102, 2'd1, 1'b1, 32'h8001FFFF, 3, 1'b0);
    check("lh_s_lit", rd_data, 32'hFFFF8001);
    txn(32'h100, 2'd1, 1'b0, 32'h8001FFFF, 0, 1'b1);
    check("lhu_lit", rd_data, 32'h0000FFFF);
    txn(32'h102, 2'd2, 1'b0, 32'h12345678, 0, 1'b0);
    txn(32'h101, 2'd1, 1'b1, 32'h12345678, 0, 1'b1);
    txn(32'h100, 2'd3, 1'b0, 32'h12345678, 0, 1'b0);
    check("err_keep_lit", rd_data, 32'h0000FFFF);
    txn(32'h200, 2'd2, 1'b0, 32'hCAFEF00D, 99, 1'b1);
    check("tmo_keep_lit", rd_data, 32'h0000FFFF);
    txn(32'h204, 2'd2, 1'b0, 32'h0BADF00D, 15, 1'b0);
    check("d15_lit", rd_data, 32'h0BADF00D);

    // Reset while a request is outstanding.
    chk_en = 1'b0;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h300; rd_size = 2'd2; rd_signed = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    check("pre_rst_req", {31'h0, mem_req}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_req",  {31'h0, mem_req}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("async_rst_data", rd_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    clear_exp(cyc);
    model_last = 32'h0;
    next_free  = cyc + 1;
    chk_en = 1'b1;

    for (int k = 0; k < 250; k++) begin
      if (next_free + 24 >= NCYC) break;
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      r = $urandom_range(0, 19);
      d = (r == 19) ? 99 : (r == 18) ? 15 : $urandom_range(0, 6);
      txn(a, sz, 1'($urandom_range(0, 1)), $urandom, d, $urandom_range(0, 3) == 0);
    end

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
